// File: rtl/serial_bus_master.sv
// Byte-stream driven 6502 bus initiator: 'W'/'R' commands from the ACIA side become bus writes/reads.
// Optional running-XOR checksum on both directions when SERIAL_BUS_MASTER_CHECKSUM_EN is defined.
module serial_bus_master #(
  parameter int BYTE_TIMEOUT = 40000,
  localparam int TW = $clog2(BYTE_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] bus_ab,
  output logic [7:0]  bus_do,
  output logic        bus_we_n,
  input  logic [7:0]  bus_di,
  output logic        busy,
  output logic        err
);

`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_AH, S_HDR_AL, S_HDR_LEN, S_WDATA, S_WREQ, S_WSTB, S_ACK,
    S_RREQ, S_RADDR, S_RWAIT, S_RSEND, S_WCHK, S_RCHK
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_HDR_AH, S_HDR_AL, S_HDR_LEN, S_WDATA, S_WREQ, S_WSTB, S_ACK,
    S_RREQ, S_RADDR, S_RWAIT, S_RSEND
  } state_t;
`endif

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] ACK_OK  = 8'h2E;
  localparam logic [7:0] ACK_BAD = 8'h21;

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  state_t        state_r;
  logic [15:0]   addr_r;
  logic [8:0]    cnt_r;
  logic [7:0]    data_r;
  logic [7:0]    csum_r;
  logic          is_wr_r;
  logic [TW-1:0] timer_r;
  logic [7:0]    tx_data_r;
  logic          tx_valid_r;
  logic          bus_req_r;
  logic          err_r;
  logic          up_r;

  logic rx_ready_s;
  logic rx_acc_s;
  logic tx_done_s;
  logic timer_hit_s;
  logic timing_s;
  logic acc_s;
  logic wstb_s;

  assign rx_acc_s    = rx_valid & rx_ready_s;
  assign tx_done_s   = tx_valid_r & tx_ready;
  assign timer_hit_s = (timer_r == TW'(BYTE_TIMEOUT - 1));

  // Byte-accepting states: also where the inter-byte timeout runs. up_r keeps rx_ready low in reset.
  always_comb begin
    rx_ready_s = 1'b0;
    timing_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        rx_ready_s = up_r;
        timing_s   = 1'b0;
      end
      S_HDR_AH, S_HDR_AL, S_HDR_LEN, S_WDATA: begin
        rx_ready_s = 1'b1;
        timing_s   = 1'b1;
      end
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
      S_WCHK: begin
        rx_ready_s = 1'b1;
        timing_s   = 1'b1;
      end
`endif
      default: begin
        rx_ready_s = 1'b0;
        timing_s   = 1'b0;
      end
    endcase
  end

  // Bus pins are only live while granted and in an access state.
  always_comb begin
    acc_s  = 1'b0;
    wstb_s = 1'b0;
    if (bus_gnt) begin
      wstb_s = (state_r == S_WSTB);
      acc_s  = (state_r == S_WSTB) || (state_r == S_RADDR) || (state_r == S_RWAIT);
    end else begin
      wstb_s = 1'b0;
      acc_s  = 1'b0;
    end
  end

  // Main command/bus FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      addr_r     <= 16'h0000;
      cnt_r      <= 9'd0;
      data_r     <= 8'h00;
      csum_r     <= 8'h00;
      is_wr_r    <= 1'b0;
      timer_r    <= {TW{1'b0}};
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      bus_req_r  <= 1'b0;
      err_r      <= 1'b0;
      up_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      up_r  <= 1'b1;
      if (timing_s && !rx_acc_s) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= {TW{1'b0}};
      end
      case (state_r)
        S_IDLE: begin
          csum_r <= 8'h00;
          if (rx_acc_s) begin
            if (rx_data == CMD_WR) begin
              is_wr_r <= 1'b1;
              state_r <= S_HDR_AH;
            end else if (rx_data == CMD_RD) begin
              is_wr_r <= 1'b0;
              state_r <= S_HDR_AH;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        S_HDR_AH: begin
          if (rx_acc_s) begin
            addr_r[15:8] <= rx_data;
            csum_r       <= csum_next(csum_r, rx_data);
            state_r      <= S_HDR_AL;
          end else if (timer_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_HDR_AL: begin
          if (rx_acc_s) begin
            addr_r[7:0] <= rx_data;
            csum_r      <= csum_next(csum_r, rx_data);
            state_r     <= S_HDR_LEN;
          end else if (timer_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_HDR_LEN: begin
          if (rx_acc_s) begin
            // A zero length byte encodes a full 256-byte block.
            cnt_r  <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            csum_r <= csum_next(csum_r, rx_data);
            if (is_wr_r) begin
              state_r <= S_WDATA;
            end else begin
              bus_req_r <= 1'b1;
              state_r   <= S_RREQ;
            end
          end else if (timer_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (rx_acc_s) begin
            data_r    <= rx_data;
            csum_r    <= csum_next(csum_r, rx_data);
            bus_req_r <= 1'b1;
            state_r   <= S_WREQ;
          end else if (timer_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_WREQ: begin
          if (bus_gnt) state_r <= S_WSTB;
        end
        S_WSTB: begin
          if (bus_gnt) begin
            bus_req_r <= 1'b0;
            addr_r    <= addr_r + 16'd1;
            cnt_r     <= cnt_r - 9'd1;
            if (cnt_r == 9'd1) begin
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
              state_r    <= S_WCHK;
`else
              tx_data_r  <= ACK_OK;
              tx_valid_r <= 1'b1;
              state_r    <= S_ACK;
`endif
            end else begin
              state_r <= S_WDATA;
            end
          end else begin
            state_r <= S_WREQ;
          end
        end
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
        S_WCHK: begin
          if (rx_acc_s) begin
            tx_valid_r <= 1'b1;
            if (rx_data == csum_r) begin
              tx_data_r <= ACK_OK;
            end else begin
              tx_data_r <= ACK_BAD;
              err_r     <= 1'b1;
            end
            state_r <= S_ACK;
          end else if (timer_hit_s) begin
            err_r   <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_RCHK: begin
          if (tx_done_s) begin
            tx_valid_r <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
`endif
        S_ACK: begin
          if (tx_done_s) begin
            tx_valid_r <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
        S_RREQ: begin
          if (bus_gnt) state_r <= S_RADDR;
        end
        S_RADDR: begin
          state_r <= bus_gnt ? S_RWAIT : S_RREQ;
        end
        S_RWAIT: begin
          if (bus_gnt) begin
            tx_data_r  <= bus_di;
            tx_valid_r <= 1'b1;
            csum_r     <= csum_next(csum_r, bus_di);
            bus_req_r  <= 1'b0;
            addr_r     <= addr_r + 16'd1;
            cnt_r      <= cnt_r - 9'd1;
            state_r    <= S_RSEND;
          end else begin
            state_r <= S_RREQ;
          end
        end
        S_RSEND: begin
          if (tx_done_s) begin
            tx_valid_r <= 1'b0;
            if (cnt_r == 9'd0) begin
`ifdef SERIAL_BUS_MASTER_CHECKSUM_EN
              tx_data_r  <= csum_r;
              tx_valid_r <= 1'b1;
              state_r    <= S_RCHK;
`else
              state_r    <= S_IDLE;
`endif
            end else begin
              bus_req_r <= 1'b1;
              state_r   <= S_RREQ;
            end
          end
        end
        default: begin
          tx_valid_r <= 1'b0;
          bus_req_r  <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_s;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign bus_req  = bus_req_r;
  assign bus_ab   = acc_s ? addr_r : 16'h0000;
  assign bus_do   = wstb_s ? data_r : 8'h00;
  assign bus_we_n = ~wstb_s;
  assign busy     = (state_r != S_IDLE);
  assign err      = err_r;

endmodule
